// File: rtl/timer1_pkg.sv
// Shared encodings for Timer/Counter1: clock-select codes, register-port
// addresses and status-flag bit positions.
package timer1_pkg;

    localparam logic [2:0] CS_STOP     = 3'b000;
    localparam logic [2:0] CS_EXT_FALL = 3'b110;
    localparam logic [2:0] CS_EXT_RISE = 3'b111;

    localparam logic [2:0] ADDR_TCNT1L = 3'd0;
    localparam logic [2:0] ADDR_TCNT1H = 3'd1;
    localparam logic [2:0] ADDR_OCR1AL = 3'd2;
    localparam logic [2:0] ADDR_OCR1AH = 3'd3;
    localparam logic [2:0] ADDR_OCR1BL = 3'd4;
    localparam logic [2:0] ADDR_OCR1BH = 3'd5;
    localparam logic [2:0] ADDR_ICR1L  = 3'd6;
    localparam logic [2:0] ADDR_ICR1H  = 3'd7;

    localparam int FLAG_TOV  = 0;
    localparam int FLAG_OCFA = 1;
    localparam int FLAG_OCFB = 2;
    localparam int FLAG_ICF  = 3;

    localparam logic [15:0] TCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/timer1_counter_pin_edge_sync.sv
// Synchronizer plus registered rise/fall pulse generator for one asynchronous
// pin, with edge detection suppressed for a short window after reset.
module pin_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_async,
    output logic rise,
    output logic fall
);

    localparam int MASK_W = $clog2(SYNC_STAGES + 2);
    localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [MASK_W-1:0]      mask_q, mask_d;
    logic                   level;
    logic                   armed;

    // The mask down-counter outlasts the synchronizer fill, so a pin that
    // was already high during reset never looks like a fresh edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_async};
        level  = sync_q[SYNC_STAGES-1];
        hist_d = level;
        armed  = (mask_q == '0);
        mask_d = armed ? mask_q : mask_q - 1'b1;
        rise_d = armed && level && !hist_q;
        fall_d = armed && !level && hist_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            mask_q <= MASK_INIT;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            mask_q <= mask_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/timer1_counter.sv
// Timer/Counter1 core: 16-bit TCNT1 with normal/CTC counting, compare A/B,
// input capture and an 8-bit register port using a shared TEMP byte.
module timer1_counter
    import timer1_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cs,
    input  logic       presc_tick,
    input  logic       t1_pin,
    input  logic       icp_pin,
    input  logic       ices,
    input  logic       ctc_en,
    input  logic [2:0] addr,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [3:0] flag_clr,
    output logic       tov,
    output logic       ocfa,
    output logic       ocfb,
    output logic       icf
);

    logic t1_rise, t1_fall, icp_rise, icp_fall;

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_t1_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_async (t1_pin),
        .rise      (t1_rise),
        .fall      (t1_fall)
    );

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_icp_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_async (icp_pin),
        .rise      (icp_rise),
        .fall      (icp_fall)
    );

    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] ocr1a_q, ocr1a_d;
    logic [15:0] ocr1b_q, ocr1b_d;
    logic [15:0] icr1_q, icr1_d;
    logic [7:0]  temp_q, temp_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  flag_set;
    logic        count_en;
    logic        capture;
    logic        tcnt_commit;

    always_comb begin
        case (cs)
            CS_STOP:     count_en = 1'b0;
            CS_EXT_FALL: count_en = t1_fall;
            CS_EXT_RISE: count_en = t1_rise;
            default:     count_en = presc_tick;
        endcase
        capture = ices ? icp_rise : icp_fall;
    end

    always_comb begin
        tcnt_d      = tcnt_q;
        ocr1a_d     = ocr1a_q;
        ocr1b_d     = ocr1b_q;
        icr1_d      = icr1_q;
        temp_d      = temp_q;
        rdata_d     = rdata_q;
        flag_set    = '0;
        tcnt_commit = we && (addr == ADDR_TCNT1L);

        if (capture) begin
            icr1_d             = tcnt_q;
            flag_set[FLAG_ICF] = 1'b1;
        end

        // A software write to TCNT1 swallows a coincident count entirely.
        if (tcnt_commit) begin
            tcnt_d = {temp_q, wdata};
        end else if (count_en) begin
            flag_set[FLAG_OCFA] = (tcnt_q == ocr1a_q);
            flag_set[FLAG_OCFB] = (tcnt_q == ocr1b_q);
            flag_set[FLAG_TOV]  = (tcnt_q == TCNT_MAX);
            tcnt_d = (ctc_en && (tcnt_q == ocr1a_q)) ? 16'h0000 : tcnt_q + 16'd1;
        end

        if (re && !we) begin
            case (addr)
                ADDR_TCNT1L: begin rdata_d = tcnt_q[7:0];  temp_d = tcnt_q[15:8];  end
                ADDR_OCR1AL: begin rdata_d = ocr1a_q[7:0]; temp_d = ocr1a_q[15:8]; end
                ADDR_OCR1BL: begin rdata_d = ocr1b_q[7:0]; temp_d = ocr1b_q[15:8]; end
                ADDR_ICR1L:  begin rdata_d = icr1_q[7:0];  temp_d = icr1_q[15:8];  end
                ADDR_TCNT1H, ADDR_OCR1AH,
                ADDR_OCR1BH, ADDR_ICR1H:  rdata_d = temp_q;
                default: ;
            endcase
        end

        if (we) begin
            case (addr)
                ADDR_TCNT1H, ADDR_OCR1AH, ADDR_OCR1BH: temp_d = wdata;
                ADDR_OCR1AL: ocr1a_d = {temp_q, wdata};
                ADDR_OCR1BL: ocr1b_d = {temp_q, wdata};
                ADDR_ICR1L, ADDR_ICR1H: ;
                default: ;
            endcase
        end

        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q  <= '0;
            ocr1a_q <= '0;
            ocr1b_q <= '0;
            icr1_q  <= '0;
            temp_q  <= '0;
            rdata_q <= '0;
            flags_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            ocr1a_q <= ocr1a_d;
            ocr1b_q <= ocr1b_d;
            icr1_q  <= icr1_d;
            temp_q  <= temp_d;
            rdata_q <= rdata_d;
            flags_q <= flags_d;
        end
    end

    assign rdata = rdata_q;
    assign tov   = flags_q[FLAG_TOV];
    assign ocfa  = flags_q[FLAG_OCFA];
    assign ocfb  = flags_q[FLAG_OCFB];
    assign icf   = flags_q[FLAG_ICF];

endmodule

// File: tb/tb_timer1_counter.sv
// Bench for timer1_counter: directed scenarios plus random traffic, every
// cycle compared against a register-level reference model.
module tb_timer1_counter;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cs;
    logic       presc_tick;
    logic       t1_pin;
    logic       icp_pin;
    logic       ices;
    logic       ctc_en;
    logic [2:0] addr;
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [3:0] flag_clr;
    logic       tov, ocfa, ocfb, icf;

    always #5 clk = ~clk;

    timer1_counter #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .presc_tick (presc_tick),
        .t1_pin     (t1_pin),
        .icp_pin    (icp_pin),
        .ices       (ices),
        .ctc_en     (ctc_en),
        .addr       (addr),
        .we         (we),
        .re         (re),
        .wdata      (wdata),
        .rdata      (rdata),
        .flag_clr   (flag_clr),
        .tov        (tov),
        .ocfa       (ocfa),
        .ocfb       (ocfb),
        .icf        (icf)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: registers indexed by addr/2 (TCNT1, OCR1A, OCR1B, ICR1).
    logic [15:0] m_reg [4];
    logic [7:0]  m_temp;
    logic [3:0]  m_flags;        // {icf, ocfb, ocfa, tov}
    logic [7:0]  m_rdata;
    bit          m_rdata_ok;
    bit          t1_hist[$];
    bit          icp_hist[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
        m_temp = 8'h00; m_flags = 4'h0; m_rdata = 8'h00; m_rdata_ok = 1;
        t1_hist.delete(); icp_hist.delete();
    endtask

    task automatic step();
        bit t1r, t1f, icpr, icpf, cnt, cap;
        int k, idx;
        logic [15:0] old;
        logic [15:0] n_reg [4];
        logic [7:0]  n_temp;
        logic [3:0]  set;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            t1_hist.push_back(t1_pin);
            icp_hist.push_back(icp_pin);
            k = t1_hist.size() - 1;
            t1r = 0; t1f = 0; icpr = 0; icpf = 0;
            // A pin level sampled SYNC_STAGES+1 edges ago versus the one
            // before it; the very first post-reset sample has no predecessor.
            if (k >= SYNC_STAGES + 2) begin
                t1r  = t1_hist[k-SYNC_STAGES-1]  && !t1_hist[k-SYNC_STAGES-2];
                t1f  = !t1_hist[k-SYNC_STAGES-1] && t1_hist[k-SYNC_STAGES-2];
                icpr = icp_hist[k-SYNC_STAGES-1]  && !icp_hist[k-SYNC_STAGES-2];
                icpf = !icp_hist[k-SYNC_STAGES-1] && icp_hist[k-SYNC_STAGES-2];
            end
            if (cs == 3'd0)      cnt = 0;
            else if (cs == 3'd6) cnt = t1f;
            else if (cs == 3'd7) cnt = t1r;
            else                 cnt = presc_tick;
            cap = ices ? icpr : icpf;

            for (int i = 0; i < 4; i++) n_reg[i] = m_reg[i];
            n_temp = m_temp;
            set = 4'h0;
            old = m_reg[0];
            if (cap) begin n_reg[3] = old; set[3] = 1; end
            if (we && addr == 3'd0) begin
                n_reg[0] = {m_temp, wdata};
            end else if (cnt) begin
                if (old == m_reg[1]) set[1] = 1;
                if (old == m_reg[2]) set[2] = 1;
                if (old == 16'hFFFF) set[0] = 1;
                n_reg[0] = (ctc_en && old == m_reg[1]) ? 16'h0000 : 16'((int'(old) + 1) % 65536);
            end
            idx = int'(addr) / 2;
            if (we) begin
                m_rdata_ok = !re ? m_rdata_ok : 0;
                if (addr[0] && addr != 3'd7) n_temp = wdata;
                if (!addr[0] && addr != 3'd0 && addr != 3'd6) n_reg[idx] = {m_temp, wdata};
            end else if (re) begin
                m_rdata_ok = 1;
                if (!addr[0]) begin
                    m_rdata = m_reg[idx][7:0];
                    n_temp  = m_reg[idx][15:8];
                end else begin
                    m_rdata = m_temp;
                end
            end
            for (int i = 0; i < 4; i++) m_reg[i] = n_reg[i];
            m_temp  = n_temp;
            m_flags = (m_flags & ~flag_clr) | set;
        end
        #1;
        chk("flags", 16'({icf, ocfb, ocfa, tov}), 16'(m_flags));
        if (m_rdata_ok) chk("rdata", 16'(rdata), 16'(m_rdata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1; step(); we = 0;
    endtask

    task automatic wr16(input logic [2:0] lo, input logic [15:0] v);
        wr(lo + 3'd1, v[15:8]);
        wr(lo, v[7:0]);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        addr = a; re = 1; step(); re = 0; d = rdata;
    endtask

    task automatic rd16(input logic [2:0] lo, output logic [15:0] v);
        logic [7:0] l, h;
        rd(lo, l);
        rd(lo + 3'd1, h);
        v = {h, l};
    endtask

    task automatic tick();
        presc_tick = 1; step(); presc_tick = 0;
    endtask

    logic [15:0] v16;
    logic [7:0]  v8, lo8, hi8;

    initial begin
        rst_n = 0; cs = 3'd0; presc_tick = 0; t1_pin = 1; icp_pin = 1;
        ices = 1; ctc_en = 0; addr = 3'd0; we = 0; re = 0; wdata = 8'h00; flag_clr = 4'h0;
        model_reset();
        idle(3);
        chk("rst_rdata", 16'(rdata), 16'h0000);
        chk("rst_flags", 16'({icf, ocfb, ocfa, tov}), 16'h0000);
        rst_n = 1;

        // Pins held high through reset must not count or capture.
        cs = 3'd7;
        idle(6);
        rd16(3'd0, v16);
        chk("mask_tcnt", v16, 16'h0000);
        chk("mask_icf", 16'(icf), 16'h0000);
        cs = 3'd0; t1_pin = 0; icp_pin = 0;
        idle(6);

        // Normal overflow.
        cs = 3'd1;
        wr16(3'd0, 16'hFFFE);
        tick(); tick();
        rd16(3'd0, v16);
        chk("ovf_tcnt", v16, 16'h0000);
        chk("ovf_tov", 16'(tov), 16'h0001);
        idle(5);
        chk("ovf_tov_sticky", 16'(tov), 16'h0001);
        flag_clr = 4'b0001; step(); flag_clr = 4'h0;
        chk("ovf_tov_clr", 16'(tov), 16'h0000);

        // CTC with OCR1A = 3.
        flag_clr = 4'hF; step(); flag_clr = 4'h0;
        wr16(3'd2, 16'h0003);
        wr16(3'd0, 16'h0000);
        ctc_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rd(3'd0, v8);
            chk("ctc_seq", 16'(v8), 16'((i + 1) % 4));
            if (i == 2) chk("ctc_ocfa_pre", 16'(ocfa), 16'h0000);
            if (i == 3) chk("ctc_ocfa", 16'(ocfa), 16'h0001);
        end
        chk("ctc_tov", 16'(tov), 16'h0000);
        ctc_en = 0;

        // Atomic read across an increment.
        wr16(3'd0, 16'h12FF);
        rd(3'd0, lo8);
        tick();
        rd(3'd1, hi8);
        chk("atomic_read", {hi8, lo8}, 16'h12FF);
        rd16(3'd0, v16);
        chk("atomic_after", v16, 16'h1300);

        // External clock, rising then falling.
        cs = 3'd7;
        wr16(3'd0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            t1_pin = 1;
            idle(3);
            rd(3'd0, v8);
            chk("ext_rise_before", 16'(v8), 16'(i));
            rd(3'd0, v8);
            chk("ext_rise_after", 16'(v8), 16'(i + 1));
            t1_pin = 0;
            idle(4);
        end
        rd16(3'd0, v16);
        chk("ext_rise_total", v16, 16'h0005);
        cs = 3'd6;
        wr16(3'd0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            t1_pin = 1; idle(4);
            t1_pin = 0; idle(4);
        end
        rd16(3'd0, v16);
        chk("ext_fall_total", v16, 16'h0005);

        // Input capture while stopped.
        cs = 3'd0;
        flag_clr = 4'hF; step(); flag_clr = 4'h0;
        wr16(3'd0, 16'h0042);
        icp_pin = 1;
        idle(3);
        chk("cap_icf_early", 16'(icf), 16'h0000);
        flag_clr = 4'b1000; step(); flag_clr = 4'h0;
        chk("cap_icf_set_wins", 16'(icf), 16'h0001);
        rd16(3'd6, v16);
        chk("cap_icr1", v16, 16'h0042);
        flag_clr = 4'b1000; step(); flag_clr = 4'h0;
        chk("cap_icf_clr", 16'(icf), 16'h0000);
        wr(3'd1, 8'h77);
        wr(3'd7, 8'hAA);
        wr(3'd6, 8'h55);
        wr(3'd0, 8'h01);
        rd16(3'd0, v16);
        chk("icr_wr_no_temp", v16, 16'h7701);
        rd16(3'd6, v16);
        chk("icr_readonly", v16, 16'h0042);

        // TCNT1 commit beats a coincident tick.
        cs = 3'd1;
        flag_clr = 4'hF; step(); flag_clr = 4'h0;
        wr16(3'd4, 16'h0010);
        wr(3'd1, 8'h00);
        addr = 3'd0; wdata = 8'h10; we = 1; presc_tick = 1;
        step();
        we = 0; presc_tick = 0;
        chk("prio_ocfb", 16'(ocfb), 16'h0000);
        rd16(3'd0, v16);
        chk("prio_tcnt", v16, 16'h0010);
        tick();
        chk("prio_ocfb_next", 16'(ocfb), 16'h0001);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 39) == 0) cs = 3'($urandom_range(0, 7));
            presc_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) t1_pin = ~t1_pin;
            if ($urandom_range(0, 15) == 0) icp_pin = ~icp_pin;
            if ($urandom_range(0, 99) == 0) ices = ~ices;
            if ($urandom_range(0, 99) == 0) ctc_en = ~ctc_en;
            addr  = 3'($urandom_range(0, 7));
            wdata = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            we    = ($urandom_range(0, 4) == 0);
            re    = ($urandom_range(0, 2) == 0);
            flag_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        rst_n = 1; we = 0; re = 0; presc_tick = 0; flag_clr = 4'h0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
